// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants, receiver state encoding and a 2-of-3 vote
//               helper for the board UART blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Byte width carried by one 8N1 frame.
  localparam int UART_DATA_BITS = 8;

  // Default number of sample_en pulses per bit period.
  localparam int UART_OVERSAMPLE_DEFAULT = 16;

  // Receiver frame-tracking states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_t;

  // 2-of-3 majority of three line samples.
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for signals asynchronous to clk.
//               Flops reset to RESET_VAL so an idle-high line does not look
//               like activity while reset releases. Also used for cts on the
//               transmit side.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops give the first stage a full clock to resolve.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : Oversampling 8N1 serial receiver with a single-entry holding
//               register, valid/ack handshake, rts flow control and
//               framing-error / overrun pulses.
//               Optional build macro UART_RX_MAJORITY_EN: every start, data
//               and stop decision becomes a 2-of-3 vote over the samples at
//               mid-1, mid and mid+1 instead of a single mid-point sample.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = UART_OVERSAMPLE_DEFAULT
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       sample_en,
  input  logic       rx,
  output logic       rts,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ack,
  output logic       framing_err,
  output logic       overrun
);

  // Width of the oversample counter; derived from OVERSAMPLE only.
  localparam int CNT_W = $clog2(OVERSAMPLE);

  // Last count of a bit period; the counter wraps to zero after it.
  localparam logic [CNT_W-1:0] c_OS_LAST = CNT_W'(OVERSAMPLE - 1);

`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the mid point, so every decision lands
  // one tick later than the single-sample build. Entering DATA at count 1
  // keeps the data windows centred exactly 16 ticks apart from mid start.
  localparam logic [CNT_W-1:0] c_START_DEC = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] c_BIT_DEC   = '0;
  localparam logic [CNT_W-1:0] c_BIT_INIT  = CNT_W'(1);
`else
  localparam logic [CNT_W-1:0] c_START_DEC = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] c_BIT_DEC   = c_OS_LAST;
  localparam logic [CNT_W-1:0] c_BIT_INIT  = '0;
`endif

  // --------------------------------------------------------------------------
  // Line synchronizer
  // --------------------------------------------------------------------------
  logic rxs;

  uart_sync2 #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d_i  (rx),
    .q_o  (rxs)
  );

  // --------------------------------------------------------------------------
  // Bit decision: either the raw mid sample or a 3-sample vote
  // --------------------------------------------------------------------------
  logic w_bit;

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] samp_q;
  logic [2:0] samp_d;

  // The history shifts on every tick, so at a decision tick it holds exactly
  // the samples from mid-1, mid and (current) mid+1.
  assign samp_d = {samp_q[1:0], rxs};
  assign w_bit  = maj3(samp_d);

  // Sample history register, advanced once per oversample tick.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      samp_q <= 3'b111;
    end else if (sample_en) begin
      samp_q <= samp_d;
    end
  end
`else
  assign w_bit = rxs;
`endif

  // --------------------------------------------------------------------------
  // Frame tracking
  // --------------------------------------------------------------------------
  uart_rx_state_t   state_q;
  logic [CNT_W-1:0] os_cnt_q;
  logic [CNT_W-1:0] os_cnt_d;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic             done_q;     // stop bit decided on the previous edge
  logic             stop_ok_q;  // value of that stop decision

  // Free-running bit-period counter with wrap at the last count.
  assign os_cnt_d = (os_cnt_q == c_OS_LAST) ? '0 : os_cnt_q + 1'b1;

  // New bits enter at the MSB so the first (LSB) bit ends up in bit 0.
  assign shift_d  = {w_bit, shift_q[7:1]};

  // Frame FSM: advances only on sample_en; done_q marks a finished frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      os_cnt_q  <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      done_q    <= 1'b0;
      stop_ok_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (sample_en) begin
        case (state_q)
          IDLE: begin
            if (!rxs) begin
              state_q  <= START;
              os_cnt_q <= '0;
            end
          end
          START: begin
            if (os_cnt_q == c_START_DEC) begin
              if (!w_bit) begin
                state_q   <= DATA;
                os_cnt_q  <= c_BIT_INIT;
                bit_cnt_q <= '0;
              end else begin
                // Low pulse shorter than half a bit: treat as line noise.
                state_q  <= IDLE;
                os_cnt_q <= '0;
              end
            end else begin
              os_cnt_q <= os_cnt_q + 1'b1;
            end
          end
          DATA: begin
            os_cnt_q <= os_cnt_d;
            if (os_cnt_q == c_BIT_DEC) begin
              shift_q   <= shift_d;
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= STOP;
              end
            end
          end
          STOP: begin
            os_cnt_q <= os_cnt_d;
            if (os_cnt_q == c_BIT_DEC) begin
              // Re-arm immediately so a start bit right after stop is seen.
              state_q   <= IDLE;
              os_cnt_q  <= '0;
              done_q    <= 1'b1;
              stop_ok_q <= w_bit;
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  // --------------------------------------------------------------------------
  // Holding register and handshake
  // --------------------------------------------------------------------------
  logic [7:0] data_q;
  logic       valid_q;
  logic       rts_q;
  logic       ferr_q;
  logic       ovr_q;

  logic       w_ack;
  logic       w_load;
  logic       w_drop;
  logic       valid_d;

  // An ack on the completion edge frees the register before the new byte
  // is considered, so that byte loads instead of overrunning.
  assign w_ack   = data_ack & valid_q;
  assign w_load  = done_q & stop_ok_q & (~valid_q | data_ack);
  assign w_drop  = done_q & stop_ok_q & valid_q & ~data_ack;
  assign valid_d = w_load | (valid_q & ~w_ack);

  // Output register: byte, valid, rts mirror and the two status pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      rts_q   <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rts_q   <= valid_d;
      ferr_q  <= done_q & ~stop_ok_q;
      ovr_q   <= w_drop;
      if (w_load) begin
        data_q <= shift_q;
      end
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign rts         = rts_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Randomized and directed stimulus for uart_rx with a
//               queue-based scoreboard. The reference model works per frame:
//               stop bit, holding-register occupancy and acks decide whether
//               a frame yields a byte, a framing error or an overrun.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int OS = 16;

`ifdef UART_RX_MAJORITY_EN
  localparam bit MAJ       = 1'b1;
  localparam int STOP_WAIT = 10;  // ticks from stop-bit start to its decision
`else
  localparam bit MAJ       = 1'b0;
  localparam int STOP_WAIT = 9;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       sample_en = 1'b0;
  logic       rx = 1'b1;
  logic       data_ack = 1'b0;
  logic       rts;
  logic [7:0] data;
  logic       data_valid;
  logic       framing_err;
  logic       overrun;

  uart_rx #(.OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .sample_en   (sample_en),
    .rx          (rx),
    .rts         (rts),
    .data        (data),
    .data_valid  (data_valid),
    .data_ack    (data_ack),
    .framing_err (framing_err),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // sample_en: one clk in every four
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk);
      #1;
      sample_en = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  typedef enum int {EV_LOAD, EV_FERR, EV_OVR} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] d;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  model_full = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: got %s data=0x%02h, expected nothing", k.name(), d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_LOAD && e.d !== d)) begin
        errors++;
        $display("FAIL scoreboard: got %s data=0x%02h, expected %s data=0x%02h",
                 k.name(), d, e.kind.name(), e.d);
      end
    end
  endtask

  // Monitor: turns DUT output activity into events and checks them in order.
  logic       prev_v = 1'b0;
  logic [7:0] prev_d = 8'h00;
  always @(negedge clk) begin
    if (nrst) begin
      if (framing_err === 1'b1) pop_cmp(EV_FERR, data);
      if (overrun === 1'b1)     pop_cmp(EV_OVR, data);
      if (data_valid === 1'b1 && (!prev_v || data !== prev_d)) begin
        pop_cmp(EV_LOAD, data);
        check("rts_with_valid", {31'd0, rts}, 32'd1);
      end
    end
    prev_v <= nrst ? data_valid : 1'b0;
    prev_d <= data;
  end

  // Advance n oversample ticks; returns 2 time units after the tick edge.
  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      while (sample_en !== 1'b1) @(posedge clk);
      #2;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data"},  {24'd0, data}, 32'h0);
    check({tag, "_valid"}, {31'd0, data_valid}, 32'h0);
    check({tag, "_rts"},   {31'd0, rts}, 32'h0);
    check({tag, "_ferr"},  {31'd0, framing_err}, 32'h0);
    check({tag, "_ovr"},   {31'd0, overrun}, 32'h0);
  endtask

  task automatic do_reset();
    rx   = 1'b1;
    nrst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    repeat (3) @(posedge clk);
    #2;
    nrst = 1'b1;
    model_full = 1'b0;
    wait_ticks(2);
  endtask

  task automatic do_ack();
    @(negedge clk);
    data_ack = 1'b1;
    @(posedge clk);
    #1;
    data_ack = 1'b0;
    check("ack_clears_valid", {31'd0, data_valid}, 32'd0);
    check("ack_clears_rts",   {31'd0, rts}, 32'd0);
    model_full = 1'b0;
    wait_ticks(1);
  endtask

  // Reference model: outcome of a completed frame from the holding state.
  task automatic model_push(input logic [7:0] b, input bit stop, input bit glitch3,
                            input bit ack_same);
    ev_t e;
    e.d = (glitch3 && !MAJ) ? (b ^ 8'h08) : b;
    if (!stop) begin
      e.kind = EV_FERR;
    end else if (model_full && !ack_same) begin
      e.kind = EV_OVR;
    end else begin
      e.kind = EV_LOAD;
      model_full = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // Drive one frame; caller is aligned just after a tick.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit glitch3,
                            input bit ack_same, input bit chk_lat, input bit abort4);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int n = 0; n < 10; n++) begin
      rx = bits[n];
      if (n == 4 && glitch3) begin
        wait_ticks(8);
        rx = ~bits[n];
        wait_ticks(1);
        rx = bits[n];
        wait_ticks(7);
      end else if (n == 5 && abort4) begin
        wait_ticks(8);
        do_reset();
        return;
      end else if (n == 9) begin
        model_push(b, stop, glitch3, ack_same);
        if (ack_same || chk_lat) begin
          wait_ticks(STOP_WAIT);
          if (chk_lat) check("lat_not_yet_valid", {31'd0, data_valid}, 32'd0);
          if (ack_same) data_ack = 1'b1;
          @(posedge clk);
          #1;
          data_ack = 1'b0;
          if (chk_lat) begin
            check("lat_valid", {31'd0, data_valid}, 32'd1);
            check("lat_rts",   {31'd0, rts}, 32'd1);
            check("lat_data",  {24'd0, data}, {24'd0, b});
          end
          wait_ticks(OS - STOP_WAIT);
        end else begin
          wait_ticks(OS);
        end
      end else begin
        wait_ticks(OS);
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    bit         rs;

    nrst = 1'b0;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #2;
    nrst = 1'b1;
    wait_ticks(2);

    // 1: plain frame, latency, ack
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    do_ack();

    // 2: ack while empty is ignored; short start glitch rejected
    do_ack();
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    check("glitch_no_valid", {31'd0, data_valid}, 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_glitch_data", {24'd0, data}, 32'h3C);
    do_ack();

    // 3: framing error then recovery
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ferr_no_valid", {31'd0, data_valid}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_ferr_data", {24'd0, data}, 32'h7E);
    do_ack();

    // 4: back-to-back overrun, then ack coincident with completion
    send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovr_keeps_data", {24'd0, data}, 32'h11);
    send_frame(8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("same_edge_data",  {24'd0, data}, 32'h33);
    check("same_edge_valid", {31'd0, data_valid}, 32'd1);
    do_ack();

    // 5: reset during data bit 4, then a clean frame
    send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_reset_data", {24'd0, data}, 32'h5A);
    do_ack();

    // 6: one-tick glitch at the middle of data bit 3
    send_frame(8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("glitch_bit3_data", {24'd0, data}, MAJ ? 32'h00 : 32'h08);
    do_ack();

    // Randomized frames, stop errors, acks and gaps
    for (int i = 0; i < 10; i++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      send_frame(rb, rs, 1'b0, 1'b0, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) do_ack();
      wait_ticks($urandom_range(0, 3));
    end
    if (model_full) do_ack();

    repeat (200) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
